if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch initiator for the pipelined RISC-V core. It holds the PC, drives the byte address to Instruction_Memory, and captures the 32-bit word that memory returns combinationally in the same cycle. Fetched words go into a 2-entry prefetch queue, which presents {pc, instruction} to decode over a valid/ready handshake. A taken branch or jump redirect from EX flushes the queue and reloads the PC.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
DEPTH, 2, prefetch queue entries; fixed at 2 (not a general FIFO depth).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
Inst_Address  output  64  byte address to Instruction_Memory; always equals the PC register.
Instruction  input  32  word returned by Instruction_Memory for Inst_Address, same cycle.
redirect_valid  input  1  EX reports a taken branch or jump this cycle.
redirect_target  input  64  new PC when redirect_valid=1.
out_valid  output  1  queue head holds a valid fetched instruction.
out_ready  input  1  decode accepts the head this cycle.
out_pc  output  64  PC of the head entry.
out_instr  output  32  instruction word of the head entry.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC <= RESET_PC; queue count <= 0; out_valid=0.
  - out_pc=0 and out_instr=32'h00000013 (NOP).
  - Takes effect immediately, mid-operation included; in-flight entries are discarded.
- Inst_Address = PC, combinational from the register. No other logic sits in that path.
- Fetch condition each cycle, with deq = out_valid & out_ready:
  - fire = (count < 2) | deq, and redirect_valid = 0.
- On fire: at the clock edge, enqueue {PC, Instruction} at the tail and set PC <= PC + 4. PC is a 64-bit add that wraps modulo 2^64; no overflow flag.
- No fire and no redirect: PC holds. Memory keeps being read at the same address, with no side effects.
- Latency: a word at PC X is captured at edge N. It is visible on out_* with out_valid=1 after edge N. Minimum fetch-to-decode latency is 1 cycle.
- Queue (count 0..2, two entries, head/tail pointers wrap modulo 2):
  - out_valid = (count != 0); out_pc/out_instr come from the head entry.
  - deq only: count-1. Enqueue only: count+1. Both: count unchanged, head and tail both advance.
  - count=2 without deq: no fetch. Entries, PC and outputs hold stable.
  - count=0: out_valid=0 and out_instr = NOP. A head entry never becomes visible in the same cycle it is fetched.
- Redirect (highest priority):
  - At the edge: count <= 0, PC <= {redirect_target[63:2], 2'b00}. Compressed instructions are unsupported, so the low bits are forced to 0.
  - No enqueue that cycle.
  - A head accepted by decode in that same cycle counts as consumed; the flush still clears the queue.
  - Next cycle: out_valid=0 and Inst_Address = new PC. The first post-redirect instruction appears one edge later.
- Stable-output rule: while out_valid=1 and out_ready=0 and no redirect, out_pc/out_instr must not change.

Decomposition:
- Shared package riscv_pkg:
  - XLEN=64, ILEN=32, INST_BYTES=4.
  - NOP_INSTR=32'h00000013, RESET_PC default.
  - Typedef fetch_entry_t {pc[63:0], instr[31:0]}.
- One sub-module is natural: if_fetch_queue.
  - 2-entry FIFO with push/pop/flush, count, and a head output.
  - if_fetch_unit owns the PC and the fire/redirect logic.

Test Plan:
- Reset, then release with out_ready=1 and memory preloaded 0x10000513, 0x00500293, 0x00000b13 at 0/4/8:
  - After edge 1: out_valid=1, out_pc=0, out_instr=0x10000513.
  - Then pc 4 → 0x00500293, then pc 8 → 0x00000b13, one per cycle.
- Backpressure, out_ready=0 from the start:
  - Queue fills after 2 edges and Inst_Address stalls at 8.
  - out_pc stays 0 and out_instr stays 0x10000513.
  - Raise out_ready: entries at 0, 4, 8 drain in order with no gaps.
- Redirect while full:
  - Assert redirect_valid with target=0x14 and out_ready=1.
  - Next cycle: out_valid=0, Inst_Address=0x14.
  - Following cycle: out_pc=0x14, out_instr=0x04c0006f.
- Misaligned redirect target=0x13: Inst_Address becomes 0x10, and out_instr=0x008000ef one cycle later.
- Asynchronous reset mid-stream (count=2, PC=0x10):
  - Drive reset=0 between clock edges.
  - out_valid=0 and Inst_Address=RESET_PC immediately, before the next edge.
- Wrap: set PC=64'hFFFF_FFFF_FFFF_FFFC via redirect. After one fire, Inst_Address=0 and out_pc=64'hFFFF_FFFF_FFFF_FFFC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch slice of the pipelined RISC-V core.
// Contents: architectural widths, the NOP encoding that is presented when no
// instruction is available, the default reset PC, the entry type held in the
// prefetch queue, and a helper that word-aligns a fetch address.
package riscv_pkg;

    localparam int XLEN       = 64;
    localparam int ILEN       = 32;
    localparam int INST_BYTES = 4;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC  = 64'h0000_0000_0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Compressed instructions are not supported, so every fetch address is
    // forced onto a 4-byte boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// Two-entry prefetch queue sitting between instruction fetch and decode.
// Ports:
//   clk, rst_n        : clock and asynchronous active-low reset
//   push, push_entry  : write push_entry at the tail this cycle
//   pop               : retire the head entry this cycle
//   flush             : discard all entries (wins over push and pop)
//   count             : number of valid entries, 0..2
//   head_entry        : contents of the oldest entry (meaningful when count != 0)
// The parent guarantees push only when there is room (count < 2 or pop) and
// pop only when count != 0.
module if_fetch_queue
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head_entry
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         head_q, head_d;
    logic         tail_q, tail_d;
    logic [1:0]   count_q, count_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) begin
                mem_d[tail_q] = push_entry;
                tail_d        = ~tail_q;
            end else begin
                tail_d = tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end else begin
                head_d = head_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; entries are cleared on reset so nothing stale is ever observable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign head_entry = mem_q[head_q];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch initiator. Holds the PC, presents it to instruction memory,
// captures the returned word into a two-entry prefetch queue and hands
// {pc, instruction} to decode over a valid/ready handshake. A redirect from EX
// flushes the queue and reloads the PC (word-aligned).
// Ports:
//   clk, reset        : clock and asynchronous active-low reset
//   Inst_Address      : byte address to instruction memory (the PC register)
//   Instruction       : word returned by memory for Inst_Address, same cycle
//   redirect_valid/_target : taken branch/jump from EX
//   out_valid/out_ready    : decode handshake
//   out_pc/out_instr       : head entry (0 / NOP when the queue is empty)
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr
);

    logic [63:0]  pc_q, pc_d;
    logic         deq_s;
    logic         fire_s;
    logic [1:0]   count_s;
    fetch_entry_t head_s;
    fetch_entry_t push_entry_s;

    // Handshake and fetch decision. A full queue can still fetch when the
    // head leaves in the same cycle; a redirect suppresses fetching.
    always_comb begin
        deq_s  = (count_s != 2'd0) & out_ready;
        fire_s = ((count_s < 2'(DEPTH)) | deq_s) & ~redirect_valid;
        push_entry_s.pc    = pc_q;
        push_entry_s.instr = Instruction;
    end

    // Next PC: redirect has priority, a fetch advances by one word (wrapping).
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_target);
        end else if (fire_s) begin
            pc_d = pc_q + 64'(INST_BYTES);
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    if_fetch_queue u_queue (
        .clk        (clk),
        .rst_n      (reset),
        .push       (fire_s),
        .push_entry (push_entry_s),
        .pop        (deq_s),
        .flush      (redirect_valid),
        .count      (count_s),
        .head_entry (head_s)
    );

    // Decode-facing view of the queue head; empty queue shows pc 0 and a NOP.
    always_comb begin
        out_valid = (count_s != 2'd0);
        if (count_s != 2'd0) begin
            out_pc    = head_s.pc;
            out_instr = head_s.instr;
        end else begin
            out_pc    = 64'h0;
            out_instr = NOP_INSTR;
        end
    end

    assign Inst_Address = pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by random
// handshake/redirect traffic, all compared against a queue-based reference model.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic [63:0] inst_address;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;

    int total;
    int bad;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc;

    if_fetch_unit #(.RESET_PC(64'h0), .DEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .Inst_Address    (inst_address),
        .Instruction     (instruction),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: a few fixed words, a deterministic pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h1000_0513;
            64'h4:   return 32'h0050_0293;
            64'h8:   return 32'h0000_0b13;
            64'h10:  return 32'h0080_00ef;
            64'h14:  return 32'h04c0_006f;
            default: return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
        endcase
    endfunction

    assign instruction = mem_word(inst_address);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = 64'h0;
    endtask

    // One clock edge of the reference behaviour, from the handshake rules.
    task automatic model_edge(input logic rv, input logic [63:0] tgt, input logic rdy);
        int  n;
        bit  deq;
        ent_t e;
        n   = mq.size();
        deq = (n != 0) && rdy;
        if (rv) begin
            mq.delete();
            m_pc = tgt & ~64'h3;
        end else begin
            if (deq) void'(mq.pop_front());
            if (n < 2 || deq) begin
                e.pc  = m_pc;
                e.ins = mem_word(m_pc);
                mq.push_back(e);
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    task automatic compare_outputs();
        check("inst_address", inst_address, m_pc);
        check("out_valid", {63'h0, out_valid}, {63'h0, mq.size() != 0});
        if (mq.size() != 0) begin
            check("out_pc", out_pc, mq[0].pc);
            check("out_instr", {32'h0, out_instr}, {32'h0, mq[0].ins});
        end else begin
            check("out_instr_empty", {32'h0, out_instr}, 64'h13);
        end
    endtask

    task automatic step(input logic rv, input logic [63:0] tgt, input logic rdy);
        redirect_valid  = rv;
        redirect_target = tgt;
        out_ready       = rdy;
        #1;
        compare_outputs();
        @(posedge clk);
        model_edge(rv, tgt, rdy);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        reset           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 64'h0;
        out_ready       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {63'h0, out_valid}, 64'h0);
        check("rst_pc", out_pc, 64'h0);
        check("rst_instr", {32'h0, out_instr}, 64'h13);
        check("rst_addr", inst_address, 64'h0);
        reset = 1'b1;

        // Streaming with decode always ready.
        step(1'b0, 64'h0, 1'b1);
        check("tp1_valid", {63'h0, out_valid}, 64'h1);
        check("tp1_pc0", out_pc, 64'h0);
        check("tp1_ins0", {32'h0, out_instr}, 64'h1000_0513);
        step(1'b0, 64'h0, 1'b1);
        check("tp1_ins4", {32'h0, out_instr}, 64'h0050_0293);
        step(1'b0, 64'h0, 1'b1);
        check("tp1_ins8", {32'h0, out_instr}, 64'h0000_0b13);

        // Backpressure from reset.
        do_reset();
        repeat (4) step(1'b0, 64'h0, 1'b0);
        check("bp_addr", inst_address, 64'h8);
        check("bp_pc", out_pc, 64'h0);
        check("bp_instr", {32'h0, out_instr}, 64'h1000_0513);
        step(1'b0, 64'h0, 1'b1);
        check("bp_drain4", out_pc, 64'h4);
        step(1'b0, 64'h0, 1'b1);
        check("bp_drain8", out_pc, 64'h8);

        // Redirect while full and being accepted.
        step(1'b0, 64'h0, 1'b0);
        step(1'b1, 64'h14, 1'b1);
        check("rd_valid", {63'h0, out_valid}, 64'h0);
        check("rd_addr", inst_address, 64'h14);
        step(1'b0, 64'h0, 1'b0);
        check("rd_pc", out_pc, 64'h14);
        check("rd_instr", {32'h0, out_instr}, 64'h04c0_006f);

        // Misaligned redirect target.
        step(1'b1, 64'h13, 1'b1);
        check("mis_addr", inst_address, 64'h10);
        step(1'b0, 64'h0, 1'b1);
        check("mis_instr", {32'h0, out_instr}, 64'h0080_00ef);

        // Asynchronous reset with a full queue at PC 0x10.
        do_reset();
        step(1'b0, 64'h0, 1'b0);
        step(1'b0, 64'h0, 1'b0);
        step(1'b0, 64'h0, 1'b1);
        step(1'b0, 64'h0, 1'b1);
        out_ready = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check("ar_valid", {63'h0, out_valid}, 64'h0);
        check("ar_addr", inst_address, 64'h0);
        check("ar_instr", {32'h0, out_instr}, 64'h13);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // PC wrap.
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        step(1'b0, 64'h0, 1'b1);
        check("wrap_addr", inst_address, 64'h0);
        check("wrap_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            logic        rv;
            logic        rdy;
            logic [63:0] tgt;
            rv  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0)
                tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            else
                tgt = {$urandom, $urandom};
            step(rv, tgt, rdy);
        end
        step(1'b0, 64'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
